// File: rtl/snn_soc_pkg.sv
// rtl/snn_soc_pkg.sv - shared SoC constants and ADC scan FSM state type
// Purpose: SoC-level sizing constants and the ADC scan controller state
//          encoding, shared by the scan controller and its users.
// Ports:   none (package).
package snn_soc_pkg;

  localparam int NUM_OUTPUTS             = 10;
  localparam int ADC_MUX_SETTLE_CYCLES   = 2;
  localparam int ADC_DONE_TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    CONV  = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } adc_scan_state_t;

endpackage

// File: rtl/adc_ch_pick.sv
// rtl/adc_ch_pick.sv - lowest enabled channel at or above a start index
// Purpose: combinational priority pick used to find the first channel of a
//          scan and the next channel after the current one.
// Ports:   act_mask - channel enable mask
//          start    - first index to consider (one bit wider than idx so that
//                     "one past the last channel" is representable)
//          found    - a set bit exists at or above start
//          idx      - index of that lowest set bit (0 when not found)
module adc_ch_pick #(
  parameter int NUM_CH = 10,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] act_mask,
  input  logic [SEL_W:0]    start,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  // Scan downward so the last hit written is the lowest qualifying index.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (act_mask[i] && (32'(start) <= $unsigned(i))) begin
        found = 1'b1;
        idx   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - bitline MUX scan controller driving a shared ADC
// Purpose: walks the enabled channels of ch_mask, settles the MUX, requests a
//          conversion per channel, collects results (0 on timeout) and
//          publishes the whole set with a one-cycle out_valid strobe.
// Ports:   clk, rst_n            - clock, async active-low reset
//          kick, abort           - start scan / cancel scan (abort wins)
//          mode_cont             - 1: rescan continuously with the latched mask
//          ch_mask               - channel enables, sampled on accepted kick
//          err_clr               - clears sticky timeout_err
//          adc_start/adc_done/adc_data - ADC handshake
//          bl_sel                - MUX select (current channel)
//          busy                  - not IDLE
//          out_valid/out_data/out_mask - result strobe, results, source mask
//          timeout_err           - sticky adc_done timeout flag
module adc_scan_ctrl
  import snn_soc_pkg::*;
#(
  parameter int NUM_CH       = NUM_OUTPUTS,
  parameter int DATA_W       = 8,
  parameter int SETTLE_CYC   = ADC_MUX_SETTLE_CYCLES,
  parameter int DONE_TIMEOUT = ADC_DONE_TIMEOUT_CYCLES,
  localparam int SEL_W       = $clog2(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           kick,
  input  logic                           abort,
  input  logic                           mode_cont,
  input  logic [NUM_CH-1:0]              ch_mask,
  input  logic                           err_clr,
  output logic                           adc_start,
  input  logic                           adc_done,
  input  logic [DATA_W-1:0]              adc_data,
  output logic [SEL_W-1:0]               bl_sel,
  output logic                           busy,
  output logic                           out_valid,
  output logic [NUM_CH-1:0][DATA_W-1:0]  out_data,
  output logic [NUM_CH-1:0]              out_mask,
  output logic                           timeout_err
);

  localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [7:0] TIMEOUT_LAST = 8'(DONE_TIMEOUT);
  // With no settle time a channel goes straight to conversion.
  localparam adc_scan_state_t FIRST_ST = (SETTLE_CYC == 0) ? CONV : SEL;

  adc_scan_state_t                state_q, state_d;
  logic [SEL_W-1:0]               cur_q, cur_d;
  logic [NUM_CH-1:0]              act_mask_q, act_mask_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  data_reg_q, data_reg_d;
  logic [SCNT_W-1:0]              scnt_q, scnt_d;
  logic [7:0]                     wcnt_q, wcnt_d;
  logic                           adc_start_q, adc_start_d;
  logic                           busy_q, busy_d;
  logic                           out_valid_q, out_valid_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  out_data_q, out_data_d;
  logic [NUM_CH-1:0]              out_mask_q, out_mask_d;
  logic                           timeout_err_q, timeout_err_d;

  logic [NUM_CH-1:0] pick_mask;
  logic [SEL_W:0]    pick_start;
  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;

  // IDLE picks from the incoming mask; STORE looks above cur; DONE restarts at 0.
  assign pick_mask  = (state_q == IDLE) ? ch_mask : act_mask_q;
  assign pick_start = (state_q == STORE) ? ({1'b0, cur_q} + {{SEL_W{1'b0}}, 1'b1}) : '0;

  adc_ch_pick #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_pick (
    .act_mask (pick_mask),
    .start    (pick_start),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    act_mask_d    = act_mask_q;
    data_reg_d    = data_reg_q;
    scnt_d        = scnt_q;
    wcnt_d        = wcnt_q;
    out_data_d    = out_data_q;
    out_mask_d    = out_mask_q;
    timeout_err_d = timeout_err_q & ~err_clr;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (kick && pick_found) begin
            act_mask_d = ch_mask;
            data_reg_d = '0;
            cur_d      = pick_idx;
            scnt_d     = '0;
            wcnt_d     = '0;
            state_d    = FIRST_ST;
          end
        end
        SEL: begin
          if (scnt_q == SETTLE_LAST) begin
            wcnt_d  = '0;
            state_d = CONV;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        CONV: begin
          // wcnt_q == 0 is the adc_start cycle, where adc_done is not accepted.
          if ((wcnt_q != 8'd0) && adc_done) begin
            data_reg_d[cur_q] = adc_data;
            state_d           = STORE;
          end else if (wcnt_q == TIMEOUT_LAST) begin
            data_reg_d[cur_q] = '0;
            timeout_err_d     = 1'b1;
            state_d           = STORE;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
        STORE: begin
          if (pick_found) begin
            cur_d   = pick_idx;
            scnt_d  = '0;
            wcnt_d  = '0;
            state_d = FIRST_ST;
          end else begin
            out_data_d = data_reg_q;
            out_mask_d = act_mask_q;
            state_d    = DONE;
          end
        end
        DONE: begin
          if (mode_cont) begin
            data_reg_d = '0;
            cur_d      = pick_idx;
            scnt_d     = '0;
            wcnt_d     = '0;
            state_d    = FIRST_ST;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Registered strobes follow the state being entered.
    adc_start_d = (state_d == CONV) && (state_q != CONV);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      act_mask_q    <= '0;
      data_reg_q    <= '0;
      scnt_q        <= '0;
      wcnt_q        <= '0;
      adc_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_mask_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      act_mask_q    <= act_mask_d;
      data_reg_q    <= data_reg_d;
      scnt_q        <= scnt_d;
      wcnt_q        <= wcnt_d;
      adc_start_q   <= adc_start_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_mask_q    <= out_mask_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign adc_start   = adc_start_q;
  assign bl_sel      = cur_q;
  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_mask    = out_mask_q;
  assign timeout_err = timeout_err_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(adc_start_q && adc_start_d));
      assert (int'(cur_q) < NUM_CH);
      assert (!out_valid_q || (state_q == DONE));
    end
  end
`endif

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb/tb_adc_scan_ctrl.sv - self-checking bench for adc_scan_ctrl
module tb_adc_scan_ctrl;
  import snn_soc_pkg::*;

  localparam int NUM_CH = 10;
  localparam int DATA_W = 8;
  localparam int SETTLE = ADC_MUX_SETTLE_CYCLES;
  localparam int TMO    = 16;
  localparam int SEL_W  = $clog2(NUM_CH);

  typedef logic [NUM_CH-1:0][DATA_W-1:0] bus_t;

  typedef struct {
    logic [NUM_CH-1:0] mask;
    int                lat;
    int                hold;
    int                base;
    int                exp_cycles;
    bus_t              exp_data;
    bit                exp_err;
    int                exp_starts;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, kick, abort, mode_cont, err_clr, adc_done;
  logic adc_start, busy, out_valid, timeout_err;
  logic [NUM_CH-1:0] ch_mask, out_mask;
  logic [DATA_W-1:0] adc_data;
  logic [SEL_W-1:0]  bl_sel;
  bus_t              out_data;

  always #5 clk = ~clk;

  adc_scan_ctrl #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SETTLE_CYC(SETTLE), .DONE_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .kick(kick), .abort(abort), .mode_cont(mode_cont),
    .ch_mask(ch_mask), .err_clr(err_clr), .adc_start(adc_start), .adc_done(adc_done),
    .adc_data(adc_data), .bl_sel(bl_sel), .busy(busy), .out_valid(out_valid),
    .out_data(out_data), .out_mask(out_mask), .timeout_err(timeout_err)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0, k0 = 0;
  int lat = 3, hold_ch = -1, resp_base = 16, cnt = 0;
  logic [DATA_W-1:0] resp_val;
  int starts, ov_cnt, ov_cyc, busy_low;
  bit saw_err;
  int sel_log[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each enabled channel costs settle + start + W + store, W capped by timeout.
  function automatic int model_cycles(input logic [NUM_CH-1:0] m, input int l, input int h);
    int t = 1;
    for (int c = 0; c < NUM_CH; c++)
      if (m[c]) t += SETTLE + 1 + ((c == h || l > TMO) ? TMO : l) + 1;
    return t;
  endfunction

  function automatic bus_t model_data(input logic [NUM_CH-1:0] m, input int l, input int h, input int b);
    bus_t r = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (m[c] && c != h && l <= TMO) r[c] = DATA_W'(b + c);
    return r;
  endfunction

  function automatic bit model_err(input logic [NUM_CH-1:0] m, input int l, input int h);
    return (h >= 0 && h < NUM_CH && m[h]) || (l > TMO);
  endfunction

  // One clock: observe outputs at the falling edge, then act as the ADC.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (adc_start) begin starts++; sel_log.push_back(int'(bl_sel)); end
    if (out_valid) begin ov_cnt++; ov_cyc = cyc; end
    if (!busy) busy_low++;
    if (timeout_err) saw_err = 1'b1;
    adc_done = 1'b0;
    adc_data = DATA_W'($urandom);
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin adc_done = 1'b1; adc_data = resp_val; end
    end
    if (adc_start && int'(bl_sel) != hold_ch) begin
      cnt      = lat;
      resp_val = DATA_W'(resp_base + int'(bl_sel));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_mon();
    starts = 0; ov_cnt = 0; ov_cyc = -1; busy_low = 0; saw_err = 1'b0;
    sel_log.delete(); cnt = 0; adc_done = 1'b0;
  endtask

  task automatic do_kick(input logic [NUM_CH-1:0] m, input int l, input int h, input int b);
    lat = l; hold_ch = h; resp_base = b;
    clr_mon();
    ch_mask = m; kick = 1'b1; k0 = cyc;
    tick();
    kick = 1'b0; ch_mask = NUM_CH'($urandom);
  endtask

  task automatic wait_ov(input int n, input int budget);
    int g = 0;
    while (ov_cnt < n && g < budget) begin tick(); g++; end
    chk("wait_out_valid", 128'(ov_cnt >= n), 128'(1));
  endtask

  task automatic chk_sel_seq(input logic [NUM_CH-1:0] m);
    int k = 0;
    bit ok = 1'b1;
    for (int c = 0; c < NUM_CH; c++)
      if (m[c]) begin
        if (k >= sel_log.size() || sel_log[k] != c) ok = 1'b0;
        k++;
      end
    if (k != sel_log.size()) ok = 1'b0;
    chk("bl_sel_sequence", 128'(ok), 128'(1));
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; kick = 1'b0; abort = 1'b0; mode_cont = 1'b0; err_clr = 1'b0;
    ch_mask = '0; adc_done = 1'b0; adc_data = '0;
    clr_mon();
    ticks(3);
    chk("reset_outputs", 128'({adc_start, bl_sel, busy, out_valid, out_data, out_mask, timeout_err}), 128'(0));
    rst_n = 1'b1;
    tick();

    // Directed vectors with spec-given latencies, then random ones from the model.
    v.mask = 10'h3FF; v.lat = 3;  v.hold = -1; v.base = 16; v.exp_cycles = 71; vecs.push_back(v);
    v.mask = 10'h005; v.lat = 3;  v.hold = -1; v.base = 16; v.exp_cycles = 15; vecs.push_back(v);
    v.mask = 10'h3FF; v.lat = 3;  v.hold = 3;  v.base = 16; v.exp_cycles = 84; vecs.push_back(v);
    v.mask = 10'h200; v.lat = 16; v.hold = -1; v.base = 7;  v.exp_cycles = 21; vecs.push_back(v);
    v.mask = 10'h001; v.lat = 1;  v.hold = -1; v.base = 99; v.exp_cycles = 6;  vecs.push_back(v);
    for (int i = 0; i < 7; i++) begin
      v.mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      v.lat  = $urandom_range(1, 20);
      v.hold = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NUM_CH - 1) : -1;
      v.base = $urandom_range(0, 255);
      v.exp_cycles = model_cycles(v.mask, v.lat, v.hold);
      vecs.push_back(v);
    end
    foreach (vecs[i]) begin
      vecs[i].exp_data   = model_data(vecs[i].mask, vecs[i].lat, vecs[i].hold, vecs[i].base);
      vecs[i].exp_err    = model_err(vecs[i].mask, vecs[i].lat, vecs[i].hold);
      vecs[i].exp_starts = $countones(vecs[i].mask);
    end

    foreach (vecs[i]) begin
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      do_kick(vecs[i].mask, vecs[i].lat, vecs[i].hold, vecs[i].base);
      wait_ov(1, 1000);
      chk("scan_latency", 128'(ov_cyc - k0), 128'(vecs[i].exp_cycles));
      chk("out_data", 128'(out_data), 128'(vecs[i].exp_data));
      chk("out_mask", 128'(out_mask), 128'(vecs[i].mask));
      chk("timeout_err", 128'(timeout_err), 128'(vecs[i].exp_err));
      chk("adc_start_count", 128'(starts), 128'(vecs[i].exp_starts));
      chk_sel_seq(vecs[i].mask);
      ticks(3);
      chk("busy_after_done", 128'(busy), 128'(0));
      chk("out_valid_count", 128'(ov_cnt), 128'(1));
      chk("out_data_held", 128'(out_data), 128'(vecs[i].exp_data));
    end

    // err_clr held through a timeout: the set must still be visible for a cycle.
    err_clr = 1'b1;
    do_kick(10'h001, 3, 0, 0);
    wait_ov(1, 200);
    chk("err_set_wins", 128'(saw_err), 128'(1));
    tick();
    chk("err_clr_clears", 128'(timeout_err), 128'(0));
    err_clr = 1'b0;

    // Kick with an empty mask does nothing.
    do_kick(10'h000, 3, -1, 16);
    ticks(10);
    chk("mask0_busy", 128'(busy), 128'(0));
    chk("mask0_starts", 128'(starts), 128'(0));

    // Kick while busy is ignored.
    do_kick(10'h3FF, 3, -1, 16);
    ticks(20);
    ch_mask = 10'h001; kick = 1'b1; tick(); kick = 1'b0;
    wait_ov(1, 200);
    chk("busy_kick_latency", 128'(ov_cyc - k0), 128'(71));
    chk("busy_kick_mask", 128'(out_mask), 128'(10'h3FF));
    ticks(80);
    chk("busy_kick_no_rescan", 128'({ov_cnt, 1'b0, busy}), 128'({32'd1, 1'b0, 1'b0}));

    // Abort in the first CONV cycle of channel 5, with a kick in the same cycle.
    do_kick(10'h3FF, 3, -1, 16);
    for (int g = 0; g < 200 && sel_log.size() < 6; g++) tick();
    chk("abort_reached_ch5", 128'(bl_sel), 128'(5));
    abort = 1'b1; kick = 1'b1; ch_mask = 10'h3FF;
    tick();
    abort = 1'b0; kick = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_no_start", 128'(adc_start), 128'(0));
    ticks(100);
    chk("abort_no_out_valid", 128'(ov_cnt), 128'(0));
    chk("abort_start_count", 128'(starts), 128'(6));
    chk("abort_kick_ignored", 128'(busy), 128'(0));
    do_kick(10'h3FF, 3, -1, 32);
    wait_ov(1, 200);
    chk("after_abort_latency", 128'(ov_cyc - k0), 128'(71));
    chk("after_abort_data", 128'(out_data), 128'(model_data(10'h3FF, 3, -1, 32)));

    // Continuous mode: back-to-back results, then drop mode_cont mid-scan.
    mode_cont = 1'b1;
    do_kick(10'h3FF, 3, -1, 16);
    wait_ov(1, 200);
    chk("cont_first", 128'(ov_cyc - k0), 128'(71));
    k0 = ov_cyc; busy_low = 0;
    wait_ov(2, 200);
    chk("cont_gap", 128'(ov_cyc - k0), 128'(71));
    chk("cont_no_idle", 128'(busy_low), 128'(0));
    chk("cont_data", 128'(out_data), 128'(model_data(10'h3FF, 3, -1, 16)));
    ticks(30);
    mode_cont = 1'b0;
    wait_ov(3, 200);
    ticks(100);
    chk("cont_stop_count", 128'(ov_cnt), 128'(3));
    chk("cont_stop_busy", 128'(busy), 128'(0));

    // Reset mid-scan after a timeout has already set the flag.
    do_kick(10'h3FF, 3, 0, 16);
    ticks(30);
    chk("pre_reset_err", 128'(timeout_err), 128'(1));
    rst_n = 1'b0;
    tick();
    chk("midscan_reset_outputs", 128'({adc_start, bl_sel, busy, out_valid, out_data, out_mask, timeout_err}), 128'(0));
    rst_n = 1'b1;
    clr_mon();
    ticks(100);
    chk("reset_no_out_valid", 128'({ov_cnt, 1'b0, busy}), 128'(0));
    do_kick(10'h0F0, 5, -1, 64);
    wait_ov(1, 200);
    chk("post_reset_latency", 128'(ov_cyc - k0), 128'(model_cycles(10'h0F0, 5, -1)));
    chk("post_reset_data", 128'(out_data), 128'(model_data(10'h0F0, 5, -1, 64)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 Parameter NUM_CH, default snn_soc_pkg::NUM_OUTPUTS (10), is the number of bitline channels behind the MUX (range 2..64).
REQ-002 Parameter DATA_W, default 8, is the ADC result width.
REQ-003 Parameter SETTLE_CYC, default snn_soc_pkg::ADC_MUX_SETTLE_CYCLES, is the MUX settle wait per channel; 0 is legal.
REQ-004 Parameter DONE_TIMEOUT, default 16, is the maximum number of cycles to wait for adc_done after adc_start (range 1..255).
REQ-005 Localparam SEL_W is $clog2(NUM_CH).
REQ-006 Reset is rst_n, asynchronous, active-low; the clock is clk.
REQ-007 Ports, as name  direction  width  meaning:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- kick  in  1  start-scan pulse.
- abort  in  1  cancel the scan in progress.
- mode_cont  in  1  0 = single scan, 1 = continuous rescan.
- ch_mask  in  NUM_CH  channel enable mask, sampled on an accepted kick.
- err_clr  in  1  clears timeout_err.
- adc_start  out  1  single-cycle convert request.
- adc_done  in  1  conversion complete; adc_data is valid in the same cycle.
- adc_data  in  DATA_W  conversion result.
- bl_sel  out  SEL_W  MUX select.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  single-cycle result strobe.
- out_data  out  NUM_CH x DATA_W  per-channel results.
- out_mask  out  NUM_CH  mask that produced out_data.
- timeout_err  out  1  sticky flag: an adc_done timeout has occurred.

Function
REQ-008 The FSM states are IDLE, SEL, CONV, STORE, DONE.
REQ-009 IDLE: a kick with ch_mask != 0 SHALL latch ch_mask as act_mask, clear data_reg, set cur to the lowest enabled channel, and go to SEL, or to CONV if SETTLE_CYC == 0.
- A kick with ch_mask == 0 is ignored.
- A kick while busy is ignored.
REQ-010 SEL: bl_sel SHALL equal cur; the FSM stays exactly SETTLE_CYC cycles, then goes to CONV.
REQ-011 CONV: adc_start SHALL be high only in the first CONV cycle.
- adc_done is accepted from the second CONV cycle onward; adc_done in any other cycle is ignored.
REQ-012 On an accepted adc_done, the FSM SHALL write adc_data into data_reg[cur] and go to STORE.
REQ-013 If DONE_TIMEOUT cycles elapse after the adc_start cycle without adc_done:
- data_reg[cur] is written 0, timeout_err is set, and the FSM goes to STORE.
REQ-014 STORE takes one cycle. If a higher enabled channel exists in act_mask, cur advances to it and the FSM goes to SEL (or CONV if SETTLE_CYC == 0); otherwise it goes to DONE.
REQ-015 DONE takes one cycle:
- out_valid = 1, out_data <= data_reg, out_mask <= act_mask.
- Next state: SEL/CONV for the lowest channel of act_mask if mode_cont == 1, else IDLE.
- In continuous mode ch_mask is not re-sampled.
REQ-016 Disabled channels SHALL read 0 in out_data.
REQ-017 out_data and out_mask SHALL hold their values until the next out_valid.
REQ-018 abort SHALL force IDLE on the next edge from any state.
- No out_valid is produced and no adc_start is issued after abort.
- If abort and kick are high in the same cycle, abort wins.
REQ-019 If err_clr and a timeout occur in the same cycle, timeout_err SHALL be set (set wins).
REQ-020 Per-channel latency SHALL be SETTLE_CYC + 1 + W + 1 cycles, where W = the number of cycles from adc_start to adc_done.
REQ-021 bl_sel SHALL never exceed NUM_CH-1 and SHALL be held stable from SEL entry through STORE.

Reset
REQ-022 Reset SHALL put the FSM in IDLE and clear every output (adc_start, bl_sel, busy, out_valid, out_data, out_mask, timeout_err) and all internal registers to 0.
REQ-023 Reset mid-scan SHALL discard the scan with no out_valid; the first kick after reset SHALL start a normal scan.

Structure
REQ-024 The adc_scan_state_t typedef and the ADC_DONE_TIMEOUT_CYCLES default SHALL live in snn_soc_pkg, next to NUM_OUTPUTS and ADC_MUX_SETTLE_CYCLES.
REQ-025 Next-channel selection SHALL be one combinational sub-module, adc_ch_pick: inputs act_mask and start index; outputs found and idx of the lowest set bit at or above start.
REQ-026 Simulation-only assertions: adc_start is never high in two consecutive cycles; bl_sel < NUM_CH; out_valid only in DONE.

Verification
REQ-027 Default parameters (10 channels, SETTLE_CYC = 2), model returns 0x10+ch 3 cycles after adc_start; kick at T with mask 0x3FF -> out_valid only at T+71, out_data[i] = 0x10+i.
REQ-028 Mask 0x005 -> bl_sel visits only 0 then 2; out_data[1] = 0; out_mask = 0x005; exactly two adc_start pulses.
REQ-029 adc_done withheld on ch3 -> ch3 result 0 after 16 cycles, timeout_err = 1, scan completes; err_clr -> timeout_err = 0.
REQ-030 mode_cont = 1 -> back-to-back out_valid 71 cycles apart with no IDLE between; mode_cont dropped mid-scan -> exactly one more out_valid, then busy = 0.
REQ-031 abort during ch5 CONV -> IDLE and busy = 0 next cycle, no out_valid; a kick in that same cycle is ignored; a later kick completes normally.
REQ-032 kick while busy ignored; kick with mask 0 ignored; rst_n low mid-scan -> all outputs 0 and no out_valid.
